// File: rtl/wr_req_router.sv
// wr_req_router
//   Routes a single master write request to one of N_PORTS slave write
//   ports selected by s_sel, waits for that slave's acknowledge and
//   returns a one-cycle completion pulse (s_ack) to the master. A select
//   value outside the implemented port range completes immediately with
//   s_err set and no slave request issued.
//
// Optional feature:
//   WR_REQ_ROUTER_TIMEOUT_EN - when defined, a transaction whose slave does
//   not acknowledge within TIMEOUT SEND cycles is abandoned and completed
//   with s_err. When undefined, SEND waits indefinitely.
//
// Ports:
//   clk      in   single clock, rising edge
//   aresetn  in   asynchronous active-low reset
//   s_req    in   master write request, held until s_ack
//   s_sel    in   target slave index
//   s_addr   in   write address
//   s_wdata  in   write data
//   s_ack    out  one-cycle completion pulse
//   s_err    out  error flag, valid with s_ack
//   m_req    out  per-slave request, one-hot or zero
//   m_addr   out  flattened per-slave addresses, slice i = port i
//   m_wdata  out  flattened per-slave write data, slice i = port i
//   m_ack    in   per-slave acknowledge
//   busy     out  high whenever the router is not idle

module wr_req_router #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = $clog2(N_PORTS),
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      s_req,
  input  logic [SEL_W-1:0]          s_sel,
  input  logic [ADDR_W-1:0]         s_addr,
  input  logic [DATA_W-1:0]         s_wdata,
  output logic                      s_ack,
  output logic                      s_err,
  output logic [N_PORTS-1:0]        m_req,
  output logic [N_PORTS*ADDR_W-1:0] m_addr,
  output logic [N_PORTS*DATA_W-1:0] m_wdata,
  input  logic [N_PORTS-1:0]        m_ack,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, SEND, RESP, ERR} state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic             sel_ok;

`ifdef WR_REQ_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Select values can exceed the port count when N_PORTS is not a power
  // of two; compare in 32 bits so N_PORTS itself never truncates.
  assign sel_ok = ({{(32-SEL_W){1'b0}}, s_sel} < 32'(N_PORTS));

  // The captured request lives directly in the selected m_addr/m_wdata
  // slice, so later changes on the master side cannot disturb it. All
  // outputs are registered; s_ack/s_err default low so they pulse once.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      sel      <= '0;
      s_ack    <= 1'b0;
      s_err    <= 1'b0;
      m_req    <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      busy     <= 1'b0;
`ifdef WR_REQ_ROUTER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      case (state)
        IDLE: begin
          if (s_req) begin
            sel  <= s_sel;
            busy <= 1'b1;
            if (sel_ok) begin
              state                              <= SEND;
              m_req[s_sel]                       <= 1'b1;
              m_addr[s_sel*ADDR_W +: ADDR_W]     <= s_addr;
              m_wdata[s_sel*DATA_W +: DATA_W]    <= s_wdata;
`ifdef WR_REQ_ROUTER_TIMEOUT_EN
              wait_cnt                           <= '0;
`endif
            end else begin
              state <= ERR;
              s_ack <= 1'b1;
              s_err <= 1'b1;
            end
          end
        end
        SEND: begin
          // Only the selected port's acknowledge counts; an ack arriving
          // in the expiry cycle still completes the write normally.
          if (m_ack[sel]) begin
            state   <= RESP;
            m_req   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            s_ack   <= 1'b1;
          end
`ifdef WR_REQ_ROUTER_TIMEOUT_EN
          // wait_cnt holds the number of earlier ack-less SEND cycles, so
          // this cycle is the TIMEOUT-th one without an acknowledge.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= ERR;
            m_req   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            s_ack   <= 1'b1;
            s_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wr_req_router.sv
// tb_wr_req_router
//   Self-checking bench for wr_req_router. One 4-port instance runs the
//   directed single-write, foreign-ack and mid-transaction reset cases; a
//   3-port instance (TIMEOUT=8) runs randomized transactions whose expected
//   cycle-by-cycle behaviour comes from a transaction-level timeline model.
//   Honours WR_REQ_ROUTER_TIMEOUT_EN when the DUT is built with it.

module tb_wr_req_router;

  logic clk;
  logic aresetn;
  int   cyc;
  int   checks;
  int   errors;
  int   last_ack_cyc;

  // 4-port instance
  logic         a_s_req;
  logic [1:0]   a_s_sel;
  logic [31:0]  a_s_addr;
  logic [31:0]  a_s_wdata;
  logic         a_s_ack;
  logic         a_s_err;
  logic [3:0]   a_m_req;
  logic [127:0] a_m_addr;
  logic [127:0] a_m_wdata;
  logic [3:0]   a_m_ack;
  logic         a_busy;

  // 3-port instance
  logic         b_s_req;
  logic [1:0]   b_s_sel;
  logic [31:0]  b_s_addr;
  logic [31:0]  b_s_wdata;
  logic         b_s_ack;
  logic         b_s_err;
  logic [2:0]   b_m_req;
  logic [95:0]  b_m_addr;
  logic [95:0]  b_m_wdata;
  logic [2:0]   b_m_ack;
  logic         b_busy;

  wr_req_router u_dut_a (
    .clk     (clk),
    .aresetn (aresetn),
    .s_req   (a_s_req),
    .s_sel   (a_s_sel),
    .s_addr  (a_s_addr),
    .s_wdata (a_s_wdata),
    .s_ack   (a_s_ack),
    .s_err   (a_s_err),
    .m_req   (a_m_req),
    .m_addr  (a_m_addr),
    .m_wdata (a_m_wdata),
    .m_ack   (a_m_ack),
    .busy    (a_busy)
  );

  wr_req_router #(.N_PORTS(3), .TIMEOUT(8)) u_dut_b (
    .clk     (clk),
    .aresetn (aresetn),
    .s_req   (b_s_req),
    .s_sel   (b_s_sel),
    .s_addr  (b_s_addr),
    .s_wdata (b_s_wdata),
    .s_ack   (b_s_ack),
    .s_err   (b_s_err),
    .m_req   (b_m_req),
    .m_addr  (b_m_addr),
    .m_wdata (b_m_wdata),
    .m_ack   (b_m_ack),
    .busy    (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index used to measure response spacing.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one transaction on the 3-port instance starting at the negedge of
  // an idle cycle. Expected behaviour: a valid select drives only its own
  // request bit and slice for waits+1 cycles, the acknowledge in the last
  // of those cycles yields s_ack the following cycle, then idle. An
  // invalid select answers with s_ack/s_err in the very next cycle.
  task automatic applyStimulus(input int sel, input int waits, input bit spurious);
    logic [31:0] addr;
    logic [31:0] data;
    logic [95:0] exp_addr;
    logic [95:0] exp_data;
    logic [2:0]  exp_req;
    addr     = $urandom;
    data     = $urandom;
    exp_addr = '0;
    exp_data = '0;
    exp_req  = '0;
    if (sel < 3) begin
      exp_addr[sel*32 +: 32] = addr;
      exp_data[sel*32 +: 32] = data;
      exp_req[sel]           = 1'b1;
    end
    b_s_req   = 1'b1;
    b_s_sel   = 2'(sel);
    b_s_addr  = addr;
    b_s_wdata = data;
    @(negedge clk);
    b_s_sel   = 2'($urandom);
    b_s_addr  = $urandom;
    b_s_wdata = $urandom;
    if (sel < 3) begin
      for (int w = 0; w <= waits; w++) begin
        checkOutput("send_m_req", 128'(b_m_req), 128'(exp_req));
        checkOutput("send_m_addr", 128'(b_m_addr), 128'(exp_addr));
        checkOutput("send_m_wdata", 128'(b_m_wdata), 128'(exp_data));
        checkOutput("send_s_ack", 128'(b_s_ack), 128'(0));
        checkOutput("send_busy", 128'(b_busy), 128'(1));
        b_m_ack = spurious ? (3'($urandom) & ~exp_req) : 3'b000;
        if (w == waits) b_m_ack = b_m_ack | exp_req;
        @(negedge clk);
      end
      b_m_ack = '0;
    end
    checkOutput("resp_s_ack", 128'(b_s_ack), 128'(1));
    checkOutput("resp_s_err", 128'(b_s_err), 128'(sel >= 3));
    checkOutput("resp_m_req", 128'(b_m_req), 128'(0));
    checkOutput("resp_m_addr", 128'(b_m_addr), 128'(0));
    checkOutput("resp_busy", 128'(b_busy), 128'(1));
    last_ack_cyc = cyc;
    b_s_req = 1'b0;
    @(negedge clk);
    checkOutput("idle_s_ack", 128'(b_s_ack), 128'(0));
    checkOutput("idle_busy", 128'(b_busy), 128'(0));
    checkOutput("idle_m_req", 128'(b_m_req), 128'(0));
  endtask

  initial begin
    int t0;
    checks    = 0;
    errors    = 0;
    aresetn   = 1'b1;
    a_s_req   = 1'b0; a_s_sel = '0; a_s_addr = '0; a_s_wdata = '0; a_m_ack = '0;
    b_s_req   = 1'b0; b_s_sel = '0; b_s_addr = '0; b_s_wdata = '0; b_m_ack = '0;
    #1 aresetn = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state of both instances.
    checkOutput("rst_a_m_req", 128'(a_m_req), 128'(0));
    checkOutput("rst_a_m_addr", a_m_addr, 128'(0));
    checkOutput("rst_a_s_ack", 128'(a_s_ack), 128'(0));
    checkOutput("rst_a_busy", 128'(a_busy), 128'(0));
    checkOutput("rst_b_m_wdata", 128'(b_m_wdata), 128'(0));
    checkOutput("rst_b_s_err", 128'(b_s_err), 128'(0));

    // Single write to port 2, requested on the first edge out of reset,
    // with a foreign ack on port 1 before the real one.
    aresetn   = 1'b1;
    a_s_req   = 1'b1;
    a_s_sel   = 2'd2;
    a_s_addr  = 32'h0000_0100;
    a_s_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    a_s_sel   = 2'd0;
    a_s_addr  = 32'hFFFF_FFFF;
    a_s_wdata = 32'h0;
    for (int c = 0; c < 4; c++) begin
      checkOutput("a_send_m_req", 128'(a_m_req), 128'(4'b0100));
      checkOutput("a_send_m_addr", a_m_addr, {32'h0, 32'h0000_0100, 32'h0, 32'h0});
      checkOutput("a_send_m_wdata", a_m_wdata, {32'h0, 32'hA5A5_A5A5, 32'h0, 32'h0});
      checkOutput("a_send_s_ack", 128'(a_s_ack), 128'(0));
      a_m_ack = (c == 3) ? 4'b0100 : ((c == 1) ? 4'b0010 : 4'b0000);
      @(negedge clk);
    end
    a_m_ack = '0;
    checkOutput("a_resp_s_ack", 128'(a_s_ack), 128'(1));
    checkOutput("a_resp_s_err", 128'(a_s_err), 128'(0));
    checkOutput("a_resp_m_req", 128'(a_m_req), 128'(0));
    a_s_req = 1'b0;
    @(negedge clk);
    checkOutput("a_idle_s_ack", 128'(a_s_ack), 128'(0));
    checkOutput("a_idle_busy", 128'(a_busy), 128'(0));

    // Reset asserted mid-SEND drops the request at once; no late s_ack.
    a_s_req   = 1'b1;
    a_s_sel   = 2'd1;
    a_s_addr  = 32'h55;
    a_s_wdata = 32'h66;
    @(negedge clk);
    checkOutput("a_pre_rst_m_req", 128'(a_m_req), 128'(4'b0010));
    #2 aresetn = 1'b0;
    #1;
    checkOutput("a_rst_m_req", 128'(a_m_req), 128'(0));
    checkOutput("a_rst_busy", 128'(a_busy), 128'(0));
    checkOutput("a_rst_m_addr", a_m_addr, 128'(0));
    a_s_req = 1'b0;
    a_m_ack = 4'b0010;
    @(negedge clk);
    aresetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("a_post_rst_s_ack", 128'(a_s_ack), 128'(0));
      checkOutput("a_post_rst_m_req", 128'(a_m_req), 128'(0));
    end
    a_m_ack = '0;

    // Out-of-range select on the 3-port instance.
    applyStimulus(3, 0, 1'b0);

    // Back-to-back with immediate acks: responses three cycles apart.
    applyStimulus(0, 0, 1'b0);
    t0 = last_ack_cyc;
    applyStimulus(1, 0, 1'b0);
    checkOutput("b2b_ack_spacing", 128'(last_ack_cyc - t0), 128'(3));

    // Acknowledge on the last cycle before a timeout would fire.
    applyStimulus(1, 7, 1'b1);

`ifdef WR_REQ_ROUTER_TIMEOUT_EN
    // No acknowledge: request held for 8 cycles, then error completion.
    b_s_req   = 1'b1;
    b_s_sel   = 2'd2;
    b_s_addr  = $urandom;
    b_s_wdata = $urandom;
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      checkOutput("to_send_m_req", 128'(b_m_req), 128'(3'b100));
      @(negedge clk);
    end
    checkOutput("to_m_req", 128'(b_m_req), 128'(0));
    checkOutput("to_s_ack", 128'(b_s_ack), 128'(1));
    checkOutput("to_s_err", 128'(b_s_err), 128'(1));
    b_s_req = 1'b0;
    @(negedge clk);
    checkOutput("to_idle_busy", 128'(b_busy), 128'(0));
`else
    // Without a timeout the router simply keeps waiting.
    applyStimulus(2, 20, 1'b1);
`endif

    // Randomized traffic with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        checkOutput("gap_busy", 128'(b_busy), 128'(0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
